// File: rtl/robertson_multiplier.sv
// ---------------------------------------------------------------------------
// robertson_multiplier
//
// Purpose
//   Sequential signed (two's complement) WIDTH x WIDTH multiplier built on
//   Robertson's add/subtract-and-shift algorithm. Each clock in RUN performs
//   one conditional add (or, on the final step, subtract) of the multiplicand
//   into the accumulator, followed by one arithmetic right shift of {A,Q}.
//   A full product takes WIDTH steps.
//
// Handshake
//   An operation is accepted on a rising edge where the block is IDLE and
//   start=1. The operands are sampled on that same edge. While busy (RUN or
//   DONE) start is ignored and the operand inputs are not looked at. done is
//   a one-cycle pulse that marks product as valid. product then holds its
//   value until the next accepted start.
//
// Parameters
//   WIDTH         operand width in bits (>= 2); product is 2*WIDTH bits
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous, active-high; clears all state, aborts a RUN
//   start         operation request, sampled only in IDLE
//   multiplicand  signed M, latched on accepted start
//   multiplier    signed Q, latched on accepted start
//   busy          high in RUN and DONE
//   done          one-cycle pulse, product valid
//   product       signed {A,Q}
// ---------------------------------------------------------------------------
module robertson_multiplier #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    // One extra bit so the step counter can never wrap inside an operation.
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [WIDTH-1:0]  m_reg;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  q_reg;
    logic [CW-1:0]     count;

    logic [WIDTH-1:0]  m_next;
    logic [WIDTH-1:0]  a_next;
    logic [WIDTH-1:0]  q_next;
    logic [CW-1:0]     count_next;

    // Sign-extended working copies. Adding or subtracting two WIDTH-bit
    // signed values always fits in WIDTH+1 bits, so the step cannot overflow.
    logic [WIDTH:0]    a_ext;
    logic [WIDTH:0]    m_ext;
    logic [WIDTH:0]    sum;
    logic              last_step;

    assign a_ext     = {a_reg[WIDTH-1], a_reg};
    assign m_ext     = {m_reg[WIDTH-1], m_reg};
    assign last_step = (count == CW'(WIDTH - 1));

    // Q[0] is the multiplier bit currently being consumed. The final bit
    // consumed is the multiplier's sign bit, which carries weight -2^(W-1),
    // so that step subtracts instead of adding.
    always_comb begin
        sum = a_ext;
        if (q_reg[0]) begin
            if (last_step) begin
                sum = a_ext - m_ext;
            end else begin
                sum = a_ext + m_ext;
            end
        end
    end

    // Next-state and datapath next values. Everything holds by default so
    // product stays stable in IDLE and DONE.
    always_comb begin
        state_next = state;
        m_next     = m_reg;
        a_next     = a_reg;
        q_next     = q_reg;
        count_next = count;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    m_next     = multiplicand;
                    q_next     = multiplier;
                    a_next     = '0;
                    count_next = '0;
                end
            end

            RUN: begin
                // Arithmetic right shift of {S,Q}: the sum's low bit moves
                // into the top of Q while Q's consumed bit falls off.
                a_next     = sum[WIDTH:1];
                q_next     = {sum[0], q_reg[WIDTH-1:1]};
                count_next = count + CW'(1);
                if (last_step) begin
                    state_next = DONE;
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            m_reg <= '0;
            a_reg <= '0;
            q_reg <= '0;
            count <= '0;
        end else begin
            state <= state_next;
            m_reg <= m_next;
            a_reg <= a_next;
            q_reg <= q_next;
            count <= count_next;
        end
    end

    // All outputs are decoded from registers, so they are glitch-free.
    assign busy    = (state == RUN) || (state == DONE);
    assign done    = (state == DONE);
    assign product = {a_reg, q_reg};

endmodule

// File: tb/tb_robertson_multiplier.sv
// ---------------------------------------------------------------------------
// tb_robertson_multiplier
//
// Purpose
//   Self-checking bench for robertson_multiplier. Two instances are built,
//   WIDTH=8 and WIDTH=16, sharing one clock and reset. Expected products come
//   from plain signed integer multiplication of the operands. Inputs are
//   driven and outputs sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_robertson_multiplier;

    logic        clk;
    logic        reset;

    logic        start8;
    logic [7:0]  m8;
    logic [7:0]  q8;
    logic        busy8;
    logic        done8;
    logic [15:0] product8;

    logic        start16;
    logic [15:0] m16;
    logic [15:0] q16;
    logic        busy16;
    logic        done16;
    logic [31:0] product16;

    int vectors;
    int miscompares;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    robertson_multiplier #(.WIDTH(8)) dut8 (
        .clk          (clk),
        .reset        (reset),
        .start        (start8),
        .multiplicand (m8),
        .multiplier   (q8),
        .busy         (busy8),
        .done         (done8),
        .product      (product8)
    );

    robertson_multiplier #(.WIDTH(16)) dut16 (
        .clk          (clk),
        .reset        (reset),
        .start        (start16),
        .multiplicand (m16),
        .multiplier   (q16),
        .busy         (busy16),
        .done         (done16),
        .product      (product16)
    );

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        return p[15:0];
    endfunction

    function automatic logic [31:0] ref16(input logic [15:0] a, input logic [15:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p[31:0];
    endfunction

    // One complete 8-bit operation from IDLE back to IDLE.
    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] exp;
        int lat;
        exp    = ref8(a, b);
        m8     = a;
        q8     = b;
        start8 = 1'b1;
        step();                          // accept edge
        start8 = 1'b0;
        chk({tag, "_busy"}, 32'(busy8), 32'd1);
        lat = 0;
        do begin
            step();
            lat++;
        end while (!done8 && lat < 40);
        chk({tag, "_lat"}, 32'(lat), 32'd8);
        chk({tag, "_prod"}, 32'(product8), 32'(exp));
        step();                          // back to IDLE
        chk({tag, "_idle"}, {30'd0, busy8, done8}, 32'd0);
        chk({tag, "_hold"}, 32'(product8), 32'(exp));
    endtask

    task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] exp;
        int lat;
        exp     = ref16(a, b);
        m16     = a;
        q16     = b;
        start16 = 1'b1;
        step();
        start16 = 1'b0;
        lat = 0;
        do begin
            step();
            lat++;
        end while (!done16 && lat < 60);
        chk({tag, "_lat"}, 32'(lat), 32'd16);
        chk({tag, "_prod"}, product16, exp);
        step();
        chk({tag, "_idle"}, {30'd0, busy16, done16}, 32'd0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [7:0]  pa [3];
        logic [7:0]  pb [3];
        logic [15:0] first_exp;
        logic [15:0] seen_prod;
        int          lat;
        int          done_cnt;

        vectors     = 0;
        miscompares = 0;
        reset   = 1'b1;
        start8  = 1'b0;
        m8      = '0;
        q8      = '0;
        start16 = 1'b0;
        m16     = '0;
        q16     = '0;

        // Reset state: start is high but reset must win.
        start8 = 1'b1;
        m8     = 8'd9;
        q8     = 8'd9;
        step();
        step();
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_done", 32'(done8), 32'd0);
        chk("rst_prod", 32'(product8), 32'd0);
        chk("rst_prod16", product16, 32'd0);
        start8 = 1'b0;
        reset  = 1'b0;
        step();

        // Basic and sign combinations.
        run8("t1_5x3",    8'd5,           8'd3);
        chk("t1_const", 32'(product8), 32'h000F);
        run8("t2_m5x3",   8'hFB,          8'd3);
        chk("t2_const", 32'(product8), 32'hFFF1);
        run8("t2_3xm5",   8'd3,           8'hFB);
        run8("t2_m5xm3",  8'hFB,          8'hFD);
        chk("t2b_const", 32'(product8), 32'h000F);
        run8("t2_0xm128", 8'd0,           8'h80);

        // Corners.
        run8("t3_m128sq", 8'h80,          8'h80);
        chk("t3_const", 32'(product8), 32'h4000);
        run8("t3_127xm128", 8'd127,       8'h80);
        chk("t3b_const", 32'(product8), 32'hC080);
        run8("t3_127sq",  8'd127,         8'd127);
        chk("t3c_const", 32'(product8), 32'h3F01);

        // start pulsed mid-RUN with new operands must be ignored.
        first_exp = ref8(8'd23, 8'hE9);
        m8     = 8'd23;
        q8     = 8'hE9;
        start8 = 1'b1;
        step();
        start8 = 1'b0;
        step();
        step();
        step();
        m8     = 8'd99;
        q8     = 8'd7;
        start8 = 1'b1;
        step();
        start8 = 1'b0;
        done_cnt  = 0;
        seen_prod = '0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done8) begin
                done_cnt++;
                seen_prod = product8;
            end
        end
        chk("t4_done_cnt", 32'(done_cnt), 32'd1);
        chk("t4_prod", 32'(seen_prod), 32'(first_exp));

        // reset at step 4 aborts the operation.
        m8     = 8'hF9;
        q8     = 8'd9;
        start8 = 1'b1;
        step();
        start8 = 1'b0;
        step();
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t5_busy", 32'(busy8), 32'd0);
        chk("t5_done", 32'(done8), 32'd0);
        chk("t5_prod", 32'(product8), 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done8 || busy8) done_cnt++;
        end
        chk("t5_quiet", 32'(done_cnt), 32'd0);
        run8("t5_fresh", 8'hF9, 8'd9);

        // start held high: back-to-back operations every WIDTH+2 cycles.
        pa[0] = 8'd17;  pb[0] = 8'hC3;
        pa[1] = 8'h81;  pb[1] = 8'd100;
        pa[2] = 8'hFF;  pb[2] = 8'hFF;
        m8     = pa[0];
        q8     = pb[0];
        start8 = 1'b1;
        step();                          // first accept
        for (int i = 0; i < 3; i++) begin
            lat = 0;
            do begin
                step();
                lat++;
            end while (!done8 && lat < 40);
            chk($sformatf("t6_gap%0d", i), 32'(lat), (i == 0) ? 32'd8 : 32'd10);
            chk($sformatf("t6_prod%0d", i), 32'(product8), 32'(ref8(pa[i], pb[i])));
            if (i < 2) begin
                m8 = pa[i+1];
                q8 = pb[i+1];
            end else begin
                start8 = 1'b0;
            end
        end
        step();
        chk("t6_idle", 32'(busy8), 32'd0);

        // Randomized sweeps.
        for (int i = 0; i < 40; i++) begin
            run8($sformatf("r8_%0d", i), 8'($urandom), 8'($urandom));
        end
        run16("c16_min", 16'h8000, 16'h8000);
        chk("c16_const", product16, 32'h4000_0000);
        run16("c16_mix", 16'h7FFF, 16'h8000);
        for (int i = 0; i < 30; i++) begin
            run16($sformatf("r16_%0d", i), 16'($urandom), 16'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
